// File: rtl/rtc_bus_driver.sv
// Address/data bus sequencer for the RTC multiplexed port (cs/a_d/rd/wr/dato).
// Optional macro RTC_BUS_RDSYNC_EN adds a 2-flop synchronizer on read data.
module rtc_bus_driver #(
    parameter int N_SETUP = 2,
    parameter int N_PULSE = 5,
    parameter int N_HOLD  = 2,
    parameter int N_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    inout  wire  [7:0] dato,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_SETUP,
        ADDR_STROBE,
        ADDR_HOLD,
        DATA_SETUP,
        DATA_STROBE,
        DATA_HOLD,
        GAP,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       oe;
    logic       rw_q;
    logic [7:0] dout;
    logic [7:0] wdata_q;
`ifdef RTC_BUS_RDSYNC_EN
    logic [7:0] sync1;
    logic [7:0] sync2;
`endif

    // Pin levels registered on entry to each state: {cs, a_d, rd, wr, oe, busy}
    function automatic logic [5:0] pins(state_t s, logic r);
        unique case (s)
            ADDR_SETUP:  pins = 6'b001111;
            ADDR_STROBE: pins = 6'b001011;
            ADDR_HOLD:   pins = 6'b001111;
            DATA_SETUP:  pins = {4'b0111, ~r, 1'b1};
            DATA_STROBE: pins = {2'b01, ~r, r, ~r, 1'b1};
            DATA_HOLD:   pins = {4'b0111, ~r, 1'b1};
            GAP:         pins = 6'b111101;
            default:     pins = 6'b111100;
        endcase
    endfunction

    function automatic state_t succ(state_t s);
        unique case (s)
            ADDR_SETUP:  succ = ADDR_STROBE;
            ADDR_STROBE: succ = ADDR_HOLD;
            ADDR_HOLD:   succ = DATA_SETUP;
            DATA_SETUP:  succ = DATA_STROBE;
            DATA_STROBE: succ = DATA_HOLD;
            DATA_HOLD:   succ = GAP;
            GAP:         succ = DONE;
            default:     succ = IDLE;
        endcase
    endfunction

    function automatic logic [3:0] len(state_t s);
        unique case (s)
            ADDR_SETUP, DATA_SETUP:   len = 4'(N_SETUP);
            ADDR_STROBE, DATA_STROBE: len = 4'(N_PULSE);
            ADDR_HOLD, DATA_HOLD:     len = 4'(N_HOLD);
            GAP:                      len = 4'(N_GAP);
            default:                  len = 4'd1;
        endcase
    endfunction

    assign dato = oe ? dout : 8'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd1;
            cs      <= 1'b1;
            a_d     <= 1'b1;
            rd      <= 1'b1;
            wr      <= 1'b1;
            oe      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
            dout    <= 8'h00;
            wdata_q <= 8'h00;
            rw_q    <= 1'b0;
`ifdef RTC_BUS_RDSYNC_EN
            sync1   <= 8'h00;
            sync2   <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= ADDR_SETUP;
                        cnt     <= len(ADDR_SETUP);
                        rw_q    <= rw;
                        wdata_q <= wdata;
                        dout    <= addr;
                        {cs, a_d, rd, wr, oe, busy} <= pins(ADDR_SETUP, rw);
                    end else begin
                        state <= IDLE;
                        cnt   <= 4'd1;
                        {cs, a_d, rd, wr, oe, busy} <= pins(IDLE, rw_q);
                    end
                end
                default: begin
                    if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= succ(state);
                        cnt   <= len(succ(state));
                        {cs, a_d, rd, wr, oe, busy} <= pins(succ(state), rw_q);
                        if (state == ADDR_HOLD) dout <= wdata_q;
                        if (state == GAP) done <= 1'b1;
                    end
                end
            endcase
`ifdef RTC_BUS_RDSYNC_EN
            // Sample two edges after rd rises, once data has crossed both flops
            sync1 <= dato;
            sync2 <= sync1;
            if (state == DATA_HOLD && cnt == 4'(N_HOLD - 1) && rw_q)
                rdata <= sync2;
`else
            if (state == DATA_STROBE && cnt == 4'd1 && rw_q)
                rdata <= dato;
`endif
        end
    end

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Directed bench for rtc_bus_driver: vector table plus multi-cycle corner cases.
module tb_rtc_bus_driver;

    localparam int S = 2;
    localparam int P = 5;
    localparam int H = 2;
    localparam int G = 4;
    localparam int CS_LOW = 2 * (S + P + H);
    localparam int LAT = 2 * (S + P + H) + G + 1;

    logic       clk;
    logic       reset;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] model_val;
    tri1  [7:0] dato;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] model;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // RTC model drives the bus only while rd is low
    assign dato = (rd == 1'b0) ? model_val : 8'bz;

    rtc_bus_driver #(
        .N_SETUP(S),
        .N_PULSE(P),
        .N_HOLD(H),
        .N_GAP(G)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rw(rw),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .busy(busy),
        .done(done),
        .dato(dato),
        .a_d(a_d),
        .cs(cs),
        .rd(rd),
        .wr(wr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cs_low;
        int aw;
        int dw;
        int rl;
        int bad_a;
        int bad_d;
        int bad_r;
        int done_cyc;
        logic [7:0] rd_at;
        cs_low = 0; aw = 0; dw = 0; rl = 0;
        bad_a = 0; bad_d = 0; bad_r = 0; done_cyc = 0;
        rd_at = 8'h00;
        rw = v.rw;
        addr = v.addr;
        wdata = v.wdata;
        model_val = v.model;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (!cs) cs_low++;
            if (!wr && !a_d) aw++;
            if (!wr && a_d) dw++;
            if (!rd) rl++;
            if (!cs && !a_d && dato != v.addr) bad_a++;
            if (!v.rw && !cs && a_d && dato != v.wdata) bad_d++;
            if (v.rw && busy && a_d && rd && dato != 8'hFF) bad_r++;
            if (done) begin
                done_cyc = n;
                rd_at = rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        $display("vector %0d rw=%0b addr=%02h", idx, v.rw, v.addr);
        check("cs_low_cycles", cs_low, CS_LOW);
        check("addr_wr_width", aw, P);
        check("data_wr_width", dw, v.rw ? 0 : P);
        check("rd_width", rl, v.rw ? P : 0);
        check("addr_on_bus", bad_a, 0);
        check("wdata_on_bus", bad_d, 0);
        check("read_bus_released", bad_r, 0);
        check("done_cycle", done_cyc, LAT);
        check("rdata_at_done", rd_at, v.exp_rdata);
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int nd;
        int d1;
        int fall2;
        logic prev_cs;

        vecs[0] = '{1'b0, 8'h21, 8'h45, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 8'h22, 8'h00, 8'h37, 8'h37};
        vecs[2] = '{1'b0, 8'h30, 8'hAA, 8'h00, 8'h37};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 8'h0F, 8'h00, 8'hA5, 8'hA5};

        reset = 1'b0;
        start = 1'b0;
        rw = 1'b0;
        addr = 8'h00;
        wdata = 8'h00;
        model_val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pins", {cs, a_d, rd, wr}, 4'b1111);
        check("reset_busy_done", {busy, done}, 2'b00);
        check("reset_rdata", rdata, 8'h00);
        check("reset_bus_released", dato, 8'hFF);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // start held for 40 cycles: exactly two back-to-back writes
        nd = 0; d1 = 0; fall2 = 0; prev_cs = cs;
        rw = 1'b0; addr = 8'h40; wdata = 8'h41;
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (nd == 1) d1 = n;
            end
            if (!cs && prev_cs && nd == 1 && fall2 == 0) fall2 = n;
            prev_cs = cs;
            if (n == 40) start = 1'b0;
        end
        check("held_start_done_count", nd, 2);
        check("held_start_first_done", d1, LAT);
        check("held_start_cs_refall", fall2, d1 + 1);
        check("held_start_rdata_kept", rdata, 8'hA5);

        // start pulses during a transaction are ignored
        nd = 0; d1 = 0;
        addr = 8'h50; wdata = 8'h51;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                nd++;
                if (nd == 1) d1 = n;
            end
            start = (n == 5 || n == 10);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_start_done_count", nd, 1);
        check("busy_start_done_cycle", d1, LAT);
        check("busy_start_idle", busy, 1'b0);

        // reset asserted mid-cycle during the write data strobe
        addr = 8'h55; wdata = 8'h66;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre_reset_data_strobe", {a_d, wr}, 2'b10);
        #4;
        reset = 1'b0;
        #1;
        check("async_reset_pins", {cs, a_d, rd, wr}, 4'b1111);
        check("async_reset_bus", dato, 8'hFF);
        check("async_reset_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        nd = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abandoned_no_done", nd, 0);
        check("abandoned_rdata", rdata, 8'h00);
        check("abandoned_cs_high", cs, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/rtc_bus_driver.md
# rtc_bus_driver

Cycle-accurate bus transaction engine for the RTC chip's multiplexed address/data port. It sits directly downstream of the RTC control FSM. The control FSM issues one register read or write per `start` pulse. This block sequences `cs`, `a_d`, `rd`, `wr` and the bidirectional `dato` bus through an address phase and a data phase, then returns read data with a one-cycle `done` pulse.

## Interface
- `N_SETUP`, default 2: cycles of setup before each strobe (legal range 1..15).
- `N_PULSE`, default 5: strobe low width in cycles (100 ns at 50 MHz; legal range 1..15).
- `N_HOLD`, default 2: cycles of hold after each strobe (legal range 1..15).
- `N_GAP`, default 4: cycles of recovery with `cs` high before `done` (legal range 1..15).
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transaction; sampled only while `busy`=0.
- `rw`  in  1  1=read, 0=write; captured with `start`.
- `addr`  in  8  RTC register address; captured with `start`.
- `wdata`  in  8  write data; captured with `start`.
- `rdata`  out  8  read data; valid from the `done` cycle until the next read's `done`.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.
- `dato`  inout  8  multiplexed RTC bus, tristated internally.
- `a_d`  out  1  0=address phase, 1=data phase.
- `cs`, `rd`, `wr`  out  1 each  active-low chip select and strobes.

## Operation
- All bus outputs are registered. There is no combinational path from inputs to pins.
- States: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, GAP, DONE.
- A single 4-bit down-counter is loaded with the phase length on each state entry. The state advances when the counter reaches 1.
- **IDLE:**
  - `cs`=`a_d`=`rd`=`wr`=1, `dato` released.
  - `start`=1 captures `rw`, `addr` and `wdata`, then moves to ADDR_SETUP.
- **ADDR_SETUP (`N_SETUP`):** `cs`=0, `a_d`=0, `dato` driven with `addr`.
- **ADDR_STROBE (`N_PULSE`):** `wr`=0. The address is always latched with `wr`, for both reads and writes.
- **ADDR_HOLD (`N_HOLD`):** `wr`=1, `addr` still driven.
- **DATA_SETUP (`N_SETUP`):**
  - `a_d`=1.
  - Write: `dato` driven with `wdata`.
  - Read: `dato` released.
- **DATA_STROBE (`N_PULSE`):**
  - Write: `wr`=0.
  - Read: `rd`=0. `dato` is sampled into `rdata` on the clock edge that ends the last strobe cycle.
- **DATA_HOLD (`N_HOLD`):**
  - Strobes high.
  - Write: `wdata` still driven.
  - Read: bus released.
- **GAP (`N_GAP`):** `cs`=1, `a_d`=1, bus released.
- **DONE (1 cycle):**
  - `done`=1, `busy`=0, bus idle.
  - A `start` in this cycle is accepted and moves directly to ADDR_SETUP.
- `rdata` is not modified by write transactions.
- `start` while `busy`=1 is ignored and not queued.

## Timing
- Reset (asynchronous, immediate, any state):
  - State goes to IDLE.
  - `cs`=`a_d`=`rd`=`wr`=1, `dato` released.
  - `busy`=0, `done`=0, `rdata`=8'h00.
  - A transaction interrupted by reset is abandoned without `done`.
- `start` sampled at edge E0. Relative to E0, with defaults:
  - `busy` rises after E0.
  - `cs` is low for exactly 2·(N_SETUP+N_PULSE+N_HOLD) = 18 cycles, starting after E0.
  - GAP lasts 4 cycles.
  - `done` is high during cycle 23 (after edge E22).
  - Total latency from `start` to `done` is 2·(S+P+H)+N_GAP+1 = 23 cycles.
- The bus is never driven while `rd`=0.
- On a read, the bus is released at least `N_SETUP` cycles before `rd` falls.
- `a_d` changes only while both strobes are high.
- Back-to-back transactions: minimum `cs`-high time is `N_GAP`+1 cycles.

## Configuration
- Macro `RTC_BUS_RDSYNC_EN`.
- **Defined:**
  - `dato` passes through a 2-flop synchronizer before sampling.
  - The sample point moves to 2 edges after `rd` rises; DATA_HOLD must satisfy `N_HOLD` ≥ 2.
  - `done` timing is unchanged.
- **Undefined:** direct sampling as described under Operation.

## Test plan
- Write, `addr`=8'h21, `wdata`=8'h45:
  - `dato`=21 while `a_d`=0 with a 5-cycle `wr` pulse.
  - Then `dato`=45 with `a_d`=1 and a second 5-cycle `wr` pulse.
  - `cs` low for 18 cycles, `done` at cycle 23.
- Read, `addr`=8'h22, bench model drives 8'h37 while `rd`=0:
  - `rdata`=8'h37 at `done`.
  - DUT `dato` is Z throughout DATA_SETUP through GAP.
- `start` held high for 40 cycles: exactly two transactions. The second one's `cs` falls the cycle after the first `done`.
- `start` pulsed at cycles 5 and 10 of a transaction: ignored, single `done`.
- `reset`=0 during DATA_STROBE of a write:
  - `cs`/`wr`/`rd`/`a_d` go to 1 and `dato` to Z within the same cycle.
  - No `done`; `rdata`=00.
- With `RTC_BUS_RDSYNC_EN`, read of 8'hA5: `rdata`=A5 at `done`, latency still 23 cycles.
